// File: rtl/cnu_layer_sched_pkg.sv
// Shared definitions for the layered CNU scheduler, message RAM and CNU wrappers.
package cnu_layer_sched_pkg;

  localparam int MSG_ADDR_W  = 12;
  localparam int MEM_LAT_DEF = 1;
  localparam int CNU_LAT_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } sched_state_e;

endpackage

// File: rtl/cnu_layer_sched_delay_line.sv
// Fixed-depth shift register carrying {valid, address, last-of-layer} alongside
// the RAM/CNU datapath pipeline. It advances every cycle and clears on reset.
module sched_delay_line
  import cnu_layer_sched_pkg::*;
#(
  parameter int DEPTH  = MEM_LAT_DEF,
  parameter int ADDR_W = MSG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              last_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]             last_q, last_d;

  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    last_d    = last_q;
    vld_d[0]  = vld_i;
    addr_d[0] = addr_i;
    last_d[0] = last_i;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      addr_q <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      last_q <= last_d;
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign addr_o = addr_q[DEPTH-1];
  assign last_o = last_q[DEPTH-1];

endmodule

// File: rtl/cnu_layer_sched.sv
// Layered LDPC schedule sequencer for one CNU: issues v2c reads, tracks them
// through the RAM and CNU pipelines, and holds off each layer until the previous one is written back.
module cnu_layer_sched
  import cnu_layer_sched_pkg::*;
#(
  parameter int ROW_W   = 8,
  parameter int LAYER_W = 4,
  parameter int ITER_W  = 4,
  parameter int ADDR_W  = MSG_ADDR_W,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNU_LAT = CNU_LAT_DEF
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ROW_W-1:0]   row_num,
  input  logic [LAYER_W-1:0] layer_num,
  input  logic [ITER_W-1:0]  iter_num,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               v2c_rd_en,
  output logic [ADDR_W-1:0]  v2c_rd_addr,
  output logic               cnu_in_vld,
  output logic               c2v_wr_en,
  output logic [ADDR_W-1:0]  c2v_wr_addr,
  output logic               layer_end,
  output logic [LAYER_W-1:0] cur_layer,
  output logic [ITER_W-1:0]  cur_iter
);

  sched_state_e       state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [ROW_W-1:0]   row_num_q, row_num_d;
  logic [LAYER_W-1:0] layer_num_q, layer_num_d;
  logic [ITER_W-1:0]  iter_num_q, iter_num_d;

  logic               rd_last;
  logic [ADDR_W-1:0]  cnu_addr;
  logic               cnu_last;
  logic               wr_last;
  logic [LAYER_W-1:0] layer_inc;
  logic [ITER_W-1:0]  iter_inc;

  assign layer_inc = layer_q + LAYER_W'(1);
  assign iter_inc  = iter_q + ITER_W'(1);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    base_d      = base_q;
    layer_d     = layer_q;
    iter_d      = iter_q;
    row_num_d   = row_num_q;
    layer_num_d = layer_num_q;
    iter_num_d  = iter_num_q;
    v2c_rd_en   = 1'b0;
    v2c_rd_addr = '0;
    rd_last     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((row_num != '0) && (layer_num != '0) && (iter_num != '0)) begin
            row_num_d   = row_num;
            layer_num_d = layer_num;
            iter_num_d  = iter_num;
            row_d       = '0;
            base_d      = '0;
            layer_d     = '0;
            iter_d      = '0;
            state_d     = ST_ISSUE;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          v2c_rd_en   = 1'b1;
          v2c_rd_addr = base_q + ADDR_W'(row_q);
          rd_last     = (row_q == row_num_q - ROW_W'(1));
          if (rd_last) begin
            row_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The last write-back of this layer is on the output this cycle, so the
        // next layer's first read lands one cycle after it.
        if (layer_end) begin
          base_d  = base_q + ADDR_W'(row_num_q);
          layer_d = layer_inc;
          state_d = ST_ISSUE;
          if (layer_inc == layer_num_q) begin
            base_d  = '0;
            layer_d = '0;
            iter_d  = iter_inc;
            if (iter_inc == iter_num_q) begin
              state_d = ST_FIN;
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      base_q      <= '0;
      layer_q     <= '0;
      iter_q      <= '0;
      row_num_q   <= '0;
      layer_num_q <= '0;
      iter_num_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      base_q      <= base_d;
      layer_q     <= layer_d;
      iter_q      <= iter_d;
      row_num_q   <= row_num_d;
      layer_num_q <= layer_num_d;
      iter_num_q  <= iter_num_d;
    end
  end

  // Split at the CNU input so the first segment yields cnu_in_vld and the
  // second continues the same token on to the write-back tap.
  sched_delay_line #(
    .DEPTH  (MEM_LAT),
    .ADDR_W (ADDR_W)
  ) u_mem_dly (
    .clk    (sys_clk),
    .rst    (rst),
    .vld_i  (v2c_rd_en),
    .addr_i (v2c_rd_addr),
    .last_i (rd_last),
    .vld_o  (cnu_in_vld),
    .addr_o (cnu_addr),
    .last_o (cnu_last)
  );

  sched_delay_line #(
    .DEPTH  (CNU_LAT),
    .ADDR_W (ADDR_W)
  ) u_cnu_dly (
    .clk    (sys_clk),
    .rst    (rst),
    .vld_i  (cnu_in_vld),
    .addr_i (cnu_addr),
    .last_i (cnu_last),
    .vld_o  (c2v_wr_en),
    .addr_o (c2v_wr_addr),
    .last_o (wr_last)
  );

  assign layer_end = c2v_wr_en & wr_last;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_FIN);
  assign cur_layer = layer_q;
  assign cur_iter  = iter_q;

endmodule

// File: tb/tb_cnu_layer_sched.sv
// Directed scoreboard bench for cnu_layer_sched: expected reads, CNU strobes and
// write-backs are queued per run from the schedule timing and popped as the DUT produces them.
module tb_cnu_layer_sched;

  localparam int PIPE = 4;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  row_num;
  logic [3:0]  layer_num;
  logic [3:0]  iter_num;
  logic        stall;
  logic        busy;
  logic        done;
  logic        v2c_rd_en;
  logic [11:0] v2c_rd_addr;
  logic        cnu_in_vld;
  logic        c2v_wr_en;
  logic [11:0] c2v_wr_addr;
  logic        layer_end;
  logic [3:0]  cur_layer;
  logic [3:0]  cur_iter;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic        last;
    logic [3:0]  layer;
    logic [3:0]  iter;
  } ev_t;

  ev_t rd_q[$];
  ev_t cnu_q[$];
  ev_t wr_q[$];
  int  done_cyc;

  always #5 sys_clk = ~sys_clk;

  cnu_layer_sched dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .start       (start),
    .row_num     (row_num),
    .layer_num   (layer_num),
    .iter_num    (iter_num),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .v2c_rd_en   (v2c_rd_en),
    .v2c_rd_addr (v2c_rd_addr),
    .cnu_in_vld  (cnu_in_vld),
    .c2v_wr_en   (c2v_wr_en),
    .c2v_wr_addr (c2v_wr_addr),
    .layer_end   (layer_end),
    .cur_layer   (cur_layer),
    .cur_iter    (cur_iter)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Samples outputs on the falling edge of cycle cyc and retires due scoreboard entries.
  task automatic checkOutput(input int cyc);
    ev_t e;
    @(negedge sys_clk);
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      e = rd_q.pop_front();
      chk("rd_en", 32'(v2c_rd_en), 32'd1);
      chk("rd_addr", 32'(v2c_rd_addr), 32'(e.addr));
      chk("cur_layer", 32'(cur_layer), 32'(e.layer));
      chk("cur_iter", 32'(cur_iter), 32'(e.iter));
    end else begin
      chk("rd_en_idle", 32'(v2c_rd_en), 32'd0);
    end
    if (cnu_q.size() > 0 && cnu_q[0].cyc == cyc) begin
      e = cnu_q.pop_front();
      chk("cnu_in_vld", 32'(cnu_in_vld), 32'd1);
    end else begin
      chk("cnu_in_vld_idle", 32'(cnu_in_vld), 32'd0);
    end
    if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
      e = wr_q.pop_front();
      chk("wr_en", 32'(c2v_wr_en), 32'd1);
      chk("wr_addr", 32'(c2v_wr_addr), 32'(e.addr));
      chk("layer_end", 32'(layer_end), 32'(e.last));
    end else begin
      chk("wr_en_idle", 32'(c2v_wr_en), 32'd0);
      chk("layer_end_idle", 32'(layer_end), 32'd0);
    end
    chk("done", 32'(done), 32'(cyc == done_cyc));
    chk("busy", 32'(busy), 32'(cyc >= 1 && cyc < done_cyc));
  endtask

  // Builds the expected schedule for one run, then drives it cycle by cycle.
  // Entered and left just after a rising edge; cycle 0 carries the start pulse.
  task automatic applyStimulus(input int r, input int l, input int it,
                               input int stall_lo, input int stall_hi, input int dup_cyc);
    int          c;
    int          lastc;
    logic [11:0] base;
    ev_t         e;
    rd_q.delete();
    cnu_q.delete();
    wr_q.delete();
    lastc = 0;
    if (r == 0 || l == 0 || it == 0) begin
      done_cyc = 1;
    end else begin
      c = 1;
      for (int i = 0; i < it; i++) begin
        base = '0;
        for (int ly = 0; ly < l; ly++) begin
          for (int rw = 0; rw < r; rw++) begin
            while (c >= stall_lo && c <= stall_hi) c++;
            e.cyc   = c;
            e.addr  = base + 12'(rw);
            e.last  = (rw == r - 1);
            e.layer = 4'(ly);
            e.iter  = 4'(i);
            rd_q.push_back(e);
            e.cyc = c + 1;
            cnu_q.push_back(e);
            e.cyc = c + PIPE;
            wr_q.push_back(e);
            lastc = c;
            c++;
          end
          c    = lastc + PIPE + 1;
          base = base + 12'(r);
        end
      end
      done_cyc = c;
    end
    $display("[TB] run R=%0d L=%0d I=%0d, done expected at cycle %0d", r, l, it, done_cyc);
    for (int cyc = 0; cyc <= done_cyc + 2; cyc++) begin
      start = (cyc == 0) || (cyc == dup_cyc);
      stall = (cyc >= stall_lo && cyc <= stall_hi);
      if (cyc == 0) begin
        row_num   = 8'(r);
        layer_num = 4'(l);
        iter_num  = 4'(it);
      end else begin
        row_num   = 8'(r + 3);
        layer_num = 4'(l + 1);
        iter_num  = 4'(it + 1);
      end
      checkOutput(cyc);
      @(posedge sys_clk);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
    chk("scoreboard_empty", 32'(rd_q.size() + cnu_q.size() + wr_q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stall     = 1'b0;
    row_num   = '0;
    layer_num = '0;
    iter_num  = '0;
    #12;
    chk("reset_strobes", 32'({v2c_rd_en, cnu_in_vld, c2v_wr_en, layer_end, busy, done}), 32'd0);
    chk("reset_state", 32'({cur_layer, cur_iter, v2c_rd_addr}), 32'd0);
    chk("reset_wr_addr", 32'(c2v_wr_addr), 32'd0);
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    @(posedge sys_clk);
    #1;

    applyStimulus(2, 1, 1, -1, -1, -1);
    applyStimulus(3, 2, 2, -1, -1, -1);
    applyStimulus(4, 1, 1, 2, 3, -1);

    // Reset in the middle of an R=4 run, then a fresh start at cycle 8.
    $display("[TB] reset abort run");
    row_num   = 8'd4;
    layer_num = 4'd1;
    iter_num  = 4'd1;
    start     = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    @(negedge sys_clk);
    chk("abort_rd0", 32'({v2c_rd_en, v2c_rd_addr}), 32'h1000);
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    chk("abort_rd1", 32'({v2c_rd_en, v2c_rd_addr}), 32'h1001);
    @(posedge sys_clk);
    #1;
    rst = 1'b1;
    for (int cyc = 3; cyc < 8; cyc++) begin
      if (cyc == 6) rst = 1'b0;
      @(negedge sys_clk);
      chk("abort_strobes", 32'({v2c_rd_en, cnu_in_vld, c2v_wr_en, layer_end, busy, done}), 32'd0);
      chk("abort_state", 32'({cur_layer, cur_iter, v2c_rd_addr}), 32'd0);
      chk("abort_wr_addr", 32'(c2v_wr_addr), 32'd0);
      @(posedge sys_clk);
      #1;
    end
    applyStimulus(4, 1, 1, -1, -1, -1);

    applyStimulus(0, 1, 1, -1, -1, -1);
    applyStimulus(2, 0, 3, -1, -1, -1);
    applyStimulus(5, 1, 1, -1, -1, 3);
    applyStimulus(3, 3, 1, 4, 4, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnu_layer_sched.md
Name: cnu_layer_sched

Overview:
- Sequences one degree-6 check node unit (CNU) through a layered LDPC decoding schedule.
- Generates v2c message-memory reads and aligns a valid strobe into the CNU's fixed-latency pipeline.
- Generates c2v write-backs and enforces the layer dependency: every write of layer k completes before layer k+1 issues its first read.
- Sits between the decoder top-level control and the CNU/message-RAM datapath.

Parameters:
- ROW_W, 8: width of the rows-per-layer count.
- LAYER_W, 4: width of the layer count.
- ITER_W, 4: width of the iteration count.
- ADDR_W, 12: message-memory address width.
- MEM_LAT, 1: v2c RAM read latency in cycles.
- CNU_LAT, 3: CNU input-to-output pipeline depth in cycles.

Ports:
- sys_clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: single-cycle start pulse, sampled only in IDLE.
- row_num, in, ROW_W: check rows per layer; latched on start.
- layer_num, in, LAYER_W: layers per iteration; latched on start.
- iter_num, in, ITER_W: iterations to run; latched on start.
- stall, in, 1: suppresses read issue in the current cycle.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle completion pulse.
- v2c_rd_en, out, 1: v2c RAM read strobe.
- v2c_rd_addr, out, ADDR_W: v2c RAM read address, equal to layer_base + row.
- cnu_in_vld, out, 1: v2c_rd_en delayed by MEM_LAT; marks valid CNU inputs.
- c2v_wr_en, out, 1: v2c_rd_en delayed by MEM_LAT+CNU_LAT.
- c2v_wr_addr, out, ADDR_W: v2c_rd_addr delayed by MEM_LAT+CNU_LAT.
- layer_end, out, 1: pulses with the last c2v_wr_en of each layer.
- cur_layer, out, LAYER_W: layer currently issuing or draining.
- cur_iter, out, ITER_W: iteration currently in progress.

Behaviour:
- Reset values: all outputs 0; state IDLE; delay lines cleared; latched configuration registers 0.
- Reset asserted mid-operation aborts immediately. No further rd/wr strobes are produced and done is not pulsed.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start with row_num, layer_num and iter_num all nonzero: latch the three values, zero the counters and layer_base, go to ISSUE.
  - start with any of the three equal to zero: go to FIN. No reads are issued.
- ISSUE, per cycle:
  - stall=0: assert v2c_rd_en; address = layer_base + row; increment row.
  - stall=1: no read; row holds.
  - After the read with row = row_num-1: go to DRAIN and clear row.
- DRAIN:
  - Wait until the delay line holds no valid entries.
  - The next layer's first read occurs exactly 1 cycle after the previous layer's last c2v_wr_en, so the per-layer period with no stalls is row_num+MEM_LAT+CNU_LAT.
  - On exit: layer_base += row_num and cur_layer++.
  - When cur_layer wraps at layer_num: layer_base=0, cur_layer=0, cur_iter++.
  - When cur_iter reaches iter_num: go to FIN instead of ISSUE.
  - stall is ignored in DRAIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Addressing:
  - layer_base is an accumulator; no multiplier.
  - Address arithmetic is modulo 2^ADDR_W.
  - Configurations with layer_num*row_num > 2^ADDR_W are unsupported.
- Delay line: a MEM_LAT+CNU_LAT stage shift register of {vld, addr, last_of_layer}. It advances every cycle regardless of stall.
- start while busy is ignored.
- Latched configuration does not change while busy.
- Timing, no stalls, R=row_num, L=layer_num, I=iter_num, start sampled at cycle 0:
  - First rd at cycle 1.
  - done at cycle 1 + I·L·(R+MEM_LAT+CNU_LAT).

Decomposition:
- Shared package: state encoding, default MEM_LAT/CNU_LAT, and the address-width constant shared with the message RAM and CNU wrappers.
- One natural sub-module: sched_delay_line, a parameterised-depth valid/address/flag shift register with clear on rst. It is reused for the cnu_in_vld and c2v_wr tap points.

Test Plan:
- R=2, L=1, I=1, start at cycle 0 -> rd_en at cycles 1–2 with addresses 0,1; cnu_in_vld at 2–3; c2v_wr_en at 5–6 with addresses 0,1; layer_end at 6; done at 7; busy high cycles 1–6.
- R=3, L=2, I=2 -> read addresses 0,1,2 then 3,4,5, repeated for the second iteration. Layer 1's first read comes 1 cycle after layer 0's last write. cur_iter=1 during the second pass; done at cycle 29.
- R=4, L=1, I=1, stall high at cycles 2–3 -> reads at cycles 1,4,5,6 with addresses 0,1,2,3; writes follow each read by 4 cycles; done at 11.
- rst asserted at cycle 3 of an R=4 run, released at 6 -> all outputs 0 from cycle 3 onward, no c2v_wr_en, no done. A fresh start at cycle 8 runs normally.
- row_num=0 with start -> done at cycle 1, no rd_en. A second start pulse during a busy R=5 run -> ignored; addresses and done timing unchanged.
